// File: rtl/ntt_stage_sequencer_pkg.sv
// ntt_pkg: shared FSM state type, op encodings and pipeline-depth helper for the NTT stage sequencer
package ntt_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic OP_NTT = 1'b0;
  localparam logic OP_MUL = 1'b1;
  function automatic int pipe_depth(input int rd_lat, input int bf_lat);
    return rd_lat + bf_lat;
  endfunction
endpackage

// File: rtl/ntt_stage_sequencer_if.sv
// ntt_stage_sequencer_if: command inputs (start/op/swap_in) and memory/array control outputs; master = sequencer, slave = user
interface ntt_stage_sequencer_if #(parameter int ADDR_W = 8, parameter int WI_W = 11);
  logic start, op, swap_in, busy, done, rd_en, rd_bank, mode, swap, wr_en, wr_bank;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [WI_W-1:0] w_idx;
  modport master (input start, op, swap_in,
                  output busy, done, rd_en, rd_addr, rd_bank, w_idx, mode, swap, wr_en, wr_addr, wr_bank);
  modport slave (output start, op, swap_in,
                 input busy, done, rd_en, rd_addr, rd_bank, w_idx, mode, swap, wr_en, wr_addr, wr_bank);
endinterface

// File: rtl/ntt_stage_sequencer_valid_delay.sv
// ntt_valid_delay: DEPTH-stage shift register (ports clk, reset, d_i, q_o) carrying tokens through the read/array pipeline
module ntt_valid_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sr_q [DEPTH];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: walks rows/stages issuing reads, aligned w_idx and delayed write-backs; ports clk, reset, bus (master), cycle_cnt when NTT_SEQ_CYCLE_CNT_EN
module ntt_stage_sequencer
  import ntt_pkg::*;
#(
  parameter int LUT_SIZE   = 1360,
  parameter int NUM_STAGES = 10,
  parameter int ROWS       = 136,
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int BF_LAT     = 4
) (
  input  logic clk,
  input  logic reset,
  ntt_stage_sequencer_if.master bus
`ifdef NTT_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0] cycle_cnt
`endif
);
  localparam int WI_W = $clog2(LUT_SIZE);
  localparam int PIPE = pipe_depth(RD_LAT, BF_LAT);
  localparam int ST_W = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  if (NUM_STAGES * ROWS > LUT_SIZE) begin : g_lut_chk
    $error("NUM_STAGES*ROWS exceeds LUT_SIZE");
  end
  if (ROWS > 2 ** ADDR_W) begin : g_rows_chk
    $error("ROWS does not fit ADDR_W");
  end
  state_t state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d, rd_addr;
  logic [ST_W-1:0] stage_q, stage_d, last_stage;
  logic [WI_W-1:0] w_base_q, w_base_d, w_idx_rd;
  logic op_q, op_d, swap_q, swap_d, rd_en, rd_bank, last_wr;
  logic [ADDR_W+1:0] wr_tok;
  assign rd_en      = state_q == ISSUE;
  assign rd_addr    = rd_en ? row_q : '0;
  assign rd_bank    = rd_en & stage_q[0];
  assign w_idx_rd   = rd_en ? (op_q == OP_MUL ? WI_W'(0) : w_base_q) + WI_W'(row_q) : '0;
  assign last_stage = op_q == OP_MUL ? '0 : ST_W'(NUM_STAGES - 1);
  // The stage is drained once its final row's write-back leaves the pipe
  assign last_wr    = bus.wr_en && bus.wr_addr == ADDR_W'(ROWS - 1);
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    stage_d  = stage_q;
    w_base_d = w_base_q;
    op_d     = op_q;
    swap_d   = swap_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d  = ISSUE;
        op_d     = bus.op;
        swap_d   = bus.swap_in;
        row_d    = '0;
        stage_d  = '0;
        w_base_d = '0;
      end
      ISSUE: begin
        row_d = row_q + 1'b1;
        if (row_q == ADDR_W'(ROWS - 1)) begin
          row_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: if (last_wr) begin
        if (stage_q == last_stage) state_d = DONE;
        else begin
          stage_d  = stage_q + 1'b1;
          w_base_d = w_base_q + WI_W'(ROWS);
          state_d  = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      stage_q  <= '0;
      w_base_q <= '0;
      op_q     <= 1'b0;
      swap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      stage_q  <= stage_d;
      w_base_q <= w_base_d;
      op_q     <= op_d;
      swap_q   <= swap_d;
    end
  end
  assign bus.busy    = state_q == ISSUE || state_q == DRAIN;
  assign bus.done    = state_q == DONE;
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.rd_bank = rd_bank;
  assign bus.mode    = op_q;
  assign bus.swap    = swap_q;
  ntt_valid_delay #(.DEPTH(RD_LAT), .WIDTH(WI_W)) u_widx_dly (
    .clk(clk), .reset(reset), .d_i(w_idx_rd), .q_o(bus.w_idx)
  );
  // Write-back targets the opposite bank of the read
  ntt_valid_delay #(.DEPTH(PIPE), .WIDTH(ADDR_W + 2)) u_wr_dly (
    .clk(clk), .reset(reset), .d_i({rd_en, rd_addr, rd_en & ~rd_bank}), .q_o(wr_tok)
  );
  assign {bus.wr_en, bus.wr_addr, bus.wr_bank} = wr_tok;
`ifdef NTT_SEQ_CYCLE_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else if (state_q == IDLE && bus.start) cnt_q <= '0;
    else if (bus.busy) cnt_q <= cnt_q + 1'b1;
  end
  assign cycle_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// tb_ntt_stage_sequencer: randomized scoreboard bench for ntt_stage_sequencer
module tb_ntt_stage_sequencer;
  localparam int LUT_SIZE = 1360, NS = 3, ROWS = 4, ADDR_W = 8, RD_LAT = 1, BF_LAT = 4;
  localparam int PIPE = RD_LAT + BF_LAT, PER = ROWS + PIPE, WI_W = $clog2(LUT_SIZE);
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  ntt_stage_sequencer_if #(.ADDR_W(ADDR_W), .WI_W(WI_W)) bus ();
`ifdef NTT_SEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif
  ntt_stage_sequencer #(
    .LUT_SIZE(LUT_SIZE), .NUM_STAGES(NS), .ROWS(ROWS),
    .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
`ifdef NTT_SEQ_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );
  typedef struct {int t; int a; int b;} ev_t;
  ev_t rq[$], wq[$], iq[$];
  int dq[$];
  int e = 0, n_vec = 0, n_err = 0, bs = 0, be = 0, t;
  logic exp_mode = 0, exp_swap = 0;
  ev_t ev;
  always @(posedge clk) e <= e + 1;
  task automatic chk(string nm, longint act, longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", nm, act, exp, e + 1);
    end
  endtask
  // Reference: every stage takes ROWS read cycles then PIPE drain cycles
  task automatic expect_run(int k, bit op, bit sw);
    int ns = op ? 1 : NS;
    for (int s = 0; s < ns; s++)
      for (int r = 0; r < ROWS; r++) begin
        int tr = k + 1 + s * PER + r;
        rq.push_back('{tr, r, s % 2});
        iq.push_back('{tr + RD_LAT, (op ? 0 : s * ROWS) + r, 0});
        wq.push_back('{tr + PIPE, r, 1 - s % 2});
      end
    dq.push_back(k + 1 + ns * PER);
    bs = k + 1;
    be = k + 1 + ns * PER;
    exp_mode = op;
    exp_swap = sw;
  endtask
  always @(negedge clk) if (!reset) begin
    t = e + 1;
    if (bus.rd_en) begin
      if (rq.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        ev = rq.pop_front();
        chk("rd_time", t, ev.t);
        chk("rd_addr", bus.rd_addr, ev.a);
        chk("rd_bank", bus.rd_bank, ev.b);
      end
    end
    if (iq.size() > 0 && iq[0].t == t) begin
      ev = iq.pop_front();
      chk("w_idx", bus.w_idx, ev.a);
    end
    if (bus.wr_en) begin
      if (wq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        ev = wq.pop_front();
        chk("wr_time", t, ev.t);
        chk("wr_addr", bus.wr_addr, ev.a);
        chk("wr_bank", bus.wr_bank, ev.b);
      end
    end
    if (bus.done) begin
      if (dq.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_time", t, dq.pop_front());
    end
    chk("busy", bus.busy, t >= bs && t < be);
    if (bus.busy) begin
      chk("mode", bus.mode, exp_mode);
      chk("swap", bus.swap, exp_swap);
    end
  end
  task automatic check_zero(string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_rd_en"}, bus.rd_en, 0);
    chk({nm, "_rd_addr"}, bus.rd_addr, 0);
    chk({nm, "_rd_bank"}, bus.rd_bank, 0);
    chk({nm, "_w_idx"}, bus.w_idx, 0);
    chk({nm, "_mode"}, bus.mode, 0);
    chk({nm, "_swap"}, bus.swap, 0);
    chk({nm, "_wr_en"}, bus.wr_en, 0);
    chk({nm, "_wr_addr"}, bus.wr_addr, 0);
    chk({nm, "_wr_bank"}, bus.wr_bank, 0);
`ifdef NTT_SEQ_CYCLE_CNT_EN
    chk({nm, "_cycle_cnt"}, cycle_cnt, 0);
`endif
  endtask
  task automatic check_empty();
    chk("rd_left", rq.size(), 0);
    chk("widx_left", iq.size(), 0);
    chk("wr_left", wq.size(), 0);
    chk("done_left", dq.size(), 0);
  endtask
  task automatic run(bit op, bit sw, bit extra, int rst_at);
    int k;
    bit got = 0;
    @(negedge clk);
    k = e + 1;
    bus.start = 1;
    bus.op = op;
    bus.swap_in = sw;
    expect_run(k, op, sw);
    @(negedge clk);
    bus.start = 0;
    bus.op = ~op;
    bus.swap_in = ~sw;
    if (extra) begin
      while (e < k + 2) @(negedge clk);
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
    end
    if (rst_at > 0) begin
      while (e < k + rst_at - 1) @(negedge clk);
      #2 reset = 1;
      rq.delete(); iq.delete(); wq.delete(); dq.delete();
      bs = 0;
      be = 0;
      #1 check_zero("rst_mid");
      repeat (2) @(negedge clk);
      #2 reset = 0;
      repeat (15) @(negedge clk);
      check_empty();
      return;
    end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = bus.done;
    end
    chk("done_seen", got, 1);
    @(negedge clk);
`ifdef NTT_SEQ_CYCLE_CNT_EN
    chk("cycle_cnt", cycle_cnt, (op ? 1 : NS) * PER);
    repeat (2) @(negedge clk);
    chk("cycle_cnt_hold", cycle_cnt, (op ? 1 : NS) * PER);
`endif
    check_empty();
  endtask
  initial begin
    bus.start = 0;
    bus.op = 0;
    bus.swap_in = 0;
    #1 reset = 1;
    #2 check_zero("rst0");
    repeat (3) @(negedge clk);
    #2 reset = 0;
    run(0, 0, 0, 0);
    run(1, 1, 1, 0);
    run(0, 0, 1, 0);
    run(0, 1, 0, 7);
    run(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
